// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the PC sequencer.
// Optional branch counter: define PC_SEQ_BRANCH_COUNT_EN.
package pc_sequencer_pkg;

    localparam int WORD_W = 16;
    localparam int OFF_W  = 9;
    localparam int FCNT_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] sext_off(
        input logic [OFF_W-1:0] off
    );
        return {{(WORD_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-request and branch-resolution handshake bundle.
// The sequencer uses the master side.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic              imem_req_o;
    logic              imem_ready_i;
    logic              br_valid_i;
    logic              br_taken_i;
    logic [WORD_W-1:0] br_pc_i;
    logic [OFF_W-1:0]  br_offset_i;
    logic              br_ready_o;

    modport master (
        output imem_req_o,
        output br_ready_o,
        input  imem_ready_i,
        input  br_valid_i,
        input  br_taken_i,
        input  br_pc_i,
        input  br_offset_i
    );

    modport slave (
        input  imem_req_o,
        input  br_ready_o,
        output imem_ready_i,
        output br_valid_i,
        output br_taken_i,
        output br_pc_i,
        output br_offset_i
    );

endinterface

// File: rtl/pc_sequencer_br_target_calc.sv
// Branch target: branch PC plus sign-extended word offset, mod 2^16.
module br_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_offset,
    output logic [WORD_W-1:0] target
);

    assign target = br_pc + sext_off(br_offset);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with RUN/FLUSH/HALT control.
// Optional taken-branch counter: define PC_SEQ_BRANCH_COUNT_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC     = 16'h0000,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              halt_i,
    pc_sequencer_if.master    bus,
    output logic [WORD_W-1:0] pc_o,
    output logic              flush_o,
    output logic [WORD_W-1:0] br_count_o
);

    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_HALT  = HALT;

    localparam logic [FCNT_W-1:0] FLUSH_LD = FCNT_W'(FLUSH_CYCLES);

    logic [1:0]        state_q, state_n;
    logic [WORD_W-1:0] pc_q, pc_n;
    logic [FCNT_W-1:0] cnt_q, cnt_n;
    logic [WORD_W-1:0] target;
    logic              st_run, st_flush, st_halt;
    logic              br_hit, fetch_go;

    br_target_calc u_tgt (
        .br_pc     (bus.br_pc_i),
        .br_offset (bus.br_offset_i),
        .target    (target)
    );

    assign st_run   = (state_q == S_RUN);
    assign st_flush = (state_q == S_FLUSH);
    assign st_halt  = (state_q == S_HALT);

    assign br_hit   = st_run & bus.br_valid_i & bus.br_taken_i;
    assign fetch_go = bus.imem_req_o & bus.imem_ready_i & ~stall_i;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        cnt_n   = cnt_q;
        unique case (1'b1)
            st_run: begin
                if (br_hit) begin
                    pc_n    = target;
                    cnt_n   = FLUSH_LD;
                    state_n = S_FLUSH;
                end else if (halt_i) begin
                    state_n = S_HALT;
                end else if (fetch_go) begin
                    pc_n = pc_q + 16'd1;
                end
            end
            st_flush: begin
                // A zero count can only appear if the state got corrupted;
                // leave FLUSH rather than wrapping the counter.
                cnt_n = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_n = halt_i ? S_HALT : S_RUN;
                end
            end
            st_halt: begin
                if (!halt_i) begin
                    state_n = S_RUN;
                end
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            cnt_q   <= cnt_n;
        end
    end

    assign pc_o           = pc_q;
    assign flush_o        = st_flush;
    assign bus.imem_req_o = st_run;
    assign bus.br_ready_o = st_run;

`ifdef PC_SEQ_BRANCH_COUNT_EN
    logic [WORD_W-1:0] bcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else if (br_hit && (bcnt_q != '1)) begin
            bcnt_q <= bcnt_q + 16'd1;
        end
    end

    assign br_count_o = bcnt_q;
`else
    assign br_count_o = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected outputs are queued
// as stimulus is applied and compared one cycle later.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        halt_i;
    logic [15:0] pc_o;
    logic        flush_o;
    logic [15:0] br_count_o;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .halt_i     (halt_i),
        .bus        (bus),
        .pc_o       (pc_o),
        .flush_o    (flush_o),
        .br_count_o (br_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        fl;
        logic        rq;
        logic        rd;
        logic [15:0] bc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] ebc    = 16'd0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bump();
`ifdef PC_SEQ_BRANCH_COUNT_EN
        ebc = ebc + 16'd1;
`endif
    endtask

    task automatic push(input logic [15:0] pc, input logic fl,
                        input logic rq);
        sb.push_back('{pc: pc, fl: fl, rq: rq, rd: rq, bc: ebc});
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pc"}, pc_o, e.pc);
        chk({tag, ".flush"}, 16'(flush_o), 16'(e.fl));
        chk({tag, ".req"}, 16'(bus.imem_req_o), 16'(e.rq));
        chk({tag, ".brdy"}, 16'(bus.br_ready_o), 16'(e.rd));
        chk({tag, ".bcnt"}, br_count_o, e.bc);
    endtask

    task automatic now(input string tag, input logic [15:0] pc,
                       input logic fl, input logic rq);
        push(pc, fl, rq);
        pop_chk(tag);
    endtask

    task automatic cyc(input string tag, input logic [15:0] pc,
                       input logic fl, input logic rq);
        push(pc, fl, rq);
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    task automatic drv(input logic rdy, input logic stl, input logic hlt,
                       input logic bv, input logic bt,
                       input logic [15:0] bpc, input logic [8:0] boff);
        bus.imem_ready_i = rdy;
        stall_i          = stl;
        halt_i           = hlt;
        bus.br_valid_i   = bv;
        bus.br_taken_i   = bt;
        bus.br_pc_i      = bpc;
        bus.br_offset_i  = boff;
    endtask

    task automatic idle();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h000);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h000);
        #2;
        now("rst", 16'h0000, 1'b0, 1'b1);
        #6;
        rst_n = 1'b1;
        idle();

        for (int i = 1; i <= 4; i++) begin
            cyc("inc", 16'(i), 1'b0, 1'b1);
        end

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 9'h1F0);
        bump();
        cyc("brA", 16'h0000, 1'b1, 1'b0);
        idle();
        cyc("brA.fl2", 16'h0000, 1'b1, 1'b0);
        cyc("brA.run", 16'h0000, 1'b0, 1'b1);
        cyc("brA.inc", 16'h0001, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800, 9'h010);
        cyc("ntk", 16'h0002, 1'b0, 1'b1);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h000);
        cyc("stall", 16'h0002, 1'b0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h000);
        cyc("nordy", 16'h0002, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 9'h005);
        bump();
        cyc("brB", 16'h0003, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 9'h000);
        cyc("brB.ign", 16'h0003, 1'b1, 1'b0);
        idle();
        cyc("brB.run", 16'h0003, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0050, 9'h100);
        bump();
        cyc("brC", 16'hFF50, 1'b1, 1'b0);
        idle();
        cyc("brC.fl2", 16'hFF50, 1'b1, 1'b0);
        cyc("brC.run", 16'hFF50, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFF00, 9'h0FF);
        bump();
        cyc("brD", 16'hFFFF, 1'b1, 1'b0);
        idle();
        cyc("brD.fl2", 16'hFFFF, 1'b1, 1'b0);
        cyc("brD.run", 16'hFFFF, 1'b0, 1'b1);
        cyc("wrap", 16'h0000, 1'b0, 1'b1);
        cyc("wrap.inc", 16'h0001, 1'b0, 1'b1);

        drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 9'h004);
        bump();
        cyc("brE", 16'h0024, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 9'h000);
        cyc("brE.fl2", 16'h0024, 1'b1, 1'b0);
        cyc("brE.halt", 16'h0024, 1'b0, 1'b0);
        cyc("brE.halt2", 16'h0024, 1'b0, 1'b0);
        idle();
        cyc("brE.run", 16'h0024, 1'b0, 1'b1);
        cyc("brE.inc", 16'h0025, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 9'h000);
        cyc("haltR", 16'h0025, 1'b0, 1'b0);
        idle();
        cyc("haltR.run", 16'h0025, 1'b0, 1'b1);
        cyc("haltR.inc", 16'h0026, 1'b0, 1'b1);

        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 9'h000);
        bump();
        cyc("brF", 16'h0040, 1'b1, 1'b0);
        idle();
        #1;
        rst_n = 1'b0;
        ebc   = 16'd0;
        #1;
        now("rstF", 16'h0000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
        cyc("rstF.inc", 16'h0001, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'(256 * (k + 1)), 9'(k));
            bump();
            cyc("brG", 16'(256 * (k + 1) + k), 1'b1, 1'b0);
            idle();
            cyc("brG.fl2", 16'(256 * (k + 1) + k), 1'b1, 1'b0);
            cyc("brG.run", 16'(256 * (k + 1) + k), 1'b0, 1'b1);
        end
        now("cnt3", 16'h0302, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
